// File: rtl/pwm_capture_writer.sv
// PWM-to-sample capture: measures pwm_in duty over each 2^SAMPLE_W-cycle frame
// and writes one saturated sample per frame, at ascending addresses, into one bank.
module pwm_capture_writer #(
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                record,
  input  logic [2:0]          swar_select,
  input  logic                pwm_in,
  output logic                wr_en,
  output logic [2:0]          wr_swar,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [SAMPLE_W-1:0] FRAME_LAST = {SAMPLE_W{1'b1}};
  localparam logic [ADDR_W-1:0]   ADDR_LAST  = {ADDR_W{1'b1}};

  // A full frame of ones counts 2^SAMPLE_W, one more than a sample can hold.
  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [SAMPLE_W:0] total);
    if (total[SAMPLE_W]) begin
      return {SAMPLE_W{1'b1}};
    end else begin
      return total[SAMPLE_W-1:0];
    end
  endfunction

  state_t                state_q, state_d;
  logic [1:0]            pwm_sync_q;
  logic [SAMPLE_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [SAMPLE_W:0]     high_cnt_q, high_cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [2:0]            wr_swar_q, wr_swar_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [SAMPLE_W-1:0]   wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [SAMPLE_W:0]     total_s;

  // Two-flop synchronizer for the asynchronous PWM pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_sync_q <= 2'b00;
    end else begin
      pwm_sync_q <= {pwm_sync_q[0], pwm_in};
    end
  end

  // Next-state, frame counting and write generation.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    high_cnt_d  = high_cnt_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_swar_d   = wr_swar_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    total_s     = high_cnt_q + (SAMPLE_W+1)'(pwm_sync_q[1]);
    case (state_q)
      ST_IDLE: begin
        if (record) begin
          state_d     = ST_CAPTURE;
          frame_cnt_d = {SAMPLE_W{1'b0}};
          high_cnt_d  = {(SAMPLE_W+1){1'b0}};
          addr_d      = {ADDR_W{1'b0}};
          wr_swar_d   = swar_select;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (!record) begin
          state_d = ST_IDLE;
        end else if (wr_en_q && (wr_addr_q == ADDR_LAST)) begin
          // Leave only once the final write is on the bus, so done follows it.
          state_d = ST_DONE;
        end else begin
          frame_cnt_d = frame_cnt_q + SAMPLE_W'(1);
          if (frame_cnt_q == FRAME_LAST) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = sat_sample(total_s);
            high_cnt_d = {(SAMPLE_W+1){1'b0}};
            addr_d     = addr_q + ADDR_W'(1);
          end else begin
            high_cnt_d = total_s;
          end
        end
      end
      ST_DONE: begin
        if (!record) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= {SAMPLE_W{1'b0}};
      high_cnt_q  <= {(SAMPLE_W+1){1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      wr_en_q     <= 1'b0;
      wr_swar_q   <= 3'd0;
      wr_addr_q   <= {ADDR_W{1'b0}};
      wr_data_q   <= {SAMPLE_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      high_cnt_q  <= high_cnt_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wr_swar_q   <= wr_swar_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_swar = wr_swar_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
